// File: rtl/psum_accumulator.sv
// Read-modify-write accumulator in front of the psum scratchpad, plus an in-order drain stream.
// Products commit to the spad 2 edges after accept at 1/cycle; the drain holds data while out_ready=0.
module psum_accumulator #(
    parameter int PROD_W         = 16,
    parameter int PSUM_W         = 24,
    parameter int ADDR_W         = 5,
    parameter int SAT_EN         = 1,
    parameter int CLEAR_ON_DRAIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_first,
    input  logic              flush,
    input  logic [5:0]        flush_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              spad_w_en,
    output logic              spad_r_en,
    output logic [ADDR_W-1:0] spad_waddr,
    output logic [ADDR_W-1:0] spad_raddr,
    output logic [PSUM_W-1:0] spad_wdata,
    input  logic [PSUM_W-1:0] spad_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [5:0]        DEPTH   = 6'(1 << ADDR_W);
    localparam logic [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_s1_v;
    logic [PROD_W-1:0]   r_s1_prod;
    logic [ADDR_W-1:0]   r_s1_addr;
    logic                r_s1_first;
    logic [5:0]          r_ptr;
    logic [5:0]          r_len;

    logic                w_accept;
    logic                w_flush_go;
    logic [5:0]          w_len_clamped;
    logic                w_drain_hs;
    logic [PSUM_W:0]     w_prod_ext;
    logic [PSUM_W:0]     w_acc_ext;
    logic [PSUM_W:0]     w_sum;
    logic [PSUM_W-1:0]   w_sat;

    assign in_ready      = (r_state == IDLE);
    assign w_accept      = in_valid && in_ready;
    assign w_flush_go    = (r_state == IDLE) && flush && (flush_len != 6'd0);
    assign w_len_clamped = (flush_len > DEPTH) ? DEPTH : flush_len;

    assign out_valid  = (r_state == DRAIN);
    assign out_last   = (r_state == DRAIN) && (r_ptr == r_len - 6'd1);
    assign out_data   = (r_state == DRAIN) ? spad_rdata : '0;
    assign w_drain_hs = out_valid && out_ready;
    assign busy       = (r_state != IDLE) || r_s1_v;

    // One guard bit is enough: a PROD_W addend cannot overflow PSUM_W+1 bits.
    assign w_prod_ext = {{(PSUM_W+1-PROD_W){r_s1_prod[PROD_W-1]}}, r_s1_prod};
    assign w_acc_ext  = {spad_rdata[PSUM_W-1], spad_rdata};
    assign w_sum      = r_s1_first ? w_prod_ext : (w_acc_ext + w_prod_ext);

    always_comb begin
        w_sat = w_sum[PSUM_W-1:0];
        if ((SAT_EN != 0) && (w_sum[PSUM_W] != w_sum[PSUM_W-1])) begin
            w_sat = w_sum[PSUM_W] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Nothing is accepted outside IDLE, so any stage product left over from the
    // flush cycle commits at the end of the single WAIT cycle, before DRAIN reads.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_flush_go) w_state_nxt = WAIT;
            WAIT:    w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_hs && out_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v     <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_addr  <= '0;
            r_s1_first <= 1'b0;
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_prod  <= in_prod;
                r_s1_addr  <= in_addr;
                r_s1_first <= in_first;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_len <= '0;
        end else if (w_flush_go) begin
            r_ptr <= '0;
            r_len <= w_len_clamped;
        end else if (w_drain_hs) begin
            r_ptr <= r_ptr + 6'd1;
        end
    end

    // Stage and drain never share the spad: the stage is always empty in DRAIN.
    always_comb begin
        spad_r_en  = 1'b0;
        spad_w_en  = 1'b0;
        spad_raddr = '0;
        spad_waddr = '0;
        spad_wdata = '0;
        if (r_s1_v) begin
            spad_r_en  = 1'b1;
            spad_raddr = r_s1_addr;
            spad_w_en  = 1'b1;
            spad_waddr = r_s1_addr;
            spad_wdata = w_sat;
        end else if (r_state == DRAIN) begin
            spad_r_en  = 1'b1;
            spad_raddr = r_ptr[ADDR_W-1:0];
            if (w_drain_hs && (CLEAR_ON_DRAIN != 0)) begin
                spad_w_en  = 1'b1;
                spad_waddr = r_ptr[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with a behavioural 32x24 spad attached.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_prod;
    logic [4:0]  in_addr;
    logic        in_first;
    logic        flush;
    logic [5:0]  flush_len;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_last;
    logic        busy;
    logic        spad_w_en;
    logic        spad_r_en;
    logic [4:0]  spad_waddr;
    logic [4:0]  spad_raddr;
    logic [23:0] spad_wdata;
    logic [23:0] spad_rdata;

    logic [23:0] spad [32];
    logic        mem_clr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign spad_rdata = spad[spad_raddr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) spad[i] <= '0;
        end else if (spad_w_en) begin
            spad[spad_waddr] <= spad_wdata;
        end
    end

    psum_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_addr    (in_addr),
        .in_first   (in_first),
        .flush      (flush),
        .flush_len  (flush_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .spad_w_en  (spad_w_en),
        .spad_r_en  (spad_r_en),
        .spad_waddr (spad_waddr),
        .spad_raddr (spad_raddr),
        .spad_wdata (spad_wdata),
        .spad_rdata (spad_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [15:0] p, input logic f);
        in_valid = 1'b1;
        in_addr  = a;
        in_prod  = p;
        in_first = f;
        tick();
    endtask

    logic       rdy_pat  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [23:0] dat_pat [6] = '{24'd11, 24'd11, 24'd22, 24'd22, 24'd22, 24'd33};
    logic       last_pat [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int  cnt;
        bit  done;
        rst       = 1'b0;
        mem_clr   = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_addr   = '0;
        in_first  = 1'b0;
        flush     = 1'b0;
        flush_len = '0;
        out_ready = 1'b0;
        #2;
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset spad_w_en", spad_w_en, 1'b0);
        chk("reset spad_r_en", spad_r_en, 1'b0);
        chk("reset out_data", out_data, 24'h0);
        repeat (2) tick();
        mem_clr = 1'b0;
        rst     = 1'b1;
        tick();

        push(5'd4, 16'd5, 1'b1);
        chk("acc wdata0", spad_wdata, 24'd5);
        chk("acc w_en0", spad_w_en, 1'b1);
        chk("acc waddr0", spad_waddr, 5'd4);
        push(5'd4, 16'hFFFD, 1'b0);
        chk("acc wdata1", spad_wdata, 24'd2);
        chk("acc in_ready", in_ready, 1'b1);
        push(5'd4, 16'd10, 1'b0);
        chk("acc wdata2", spad_wdata, 24'd12);
        in_valid = 1'b0;
        tick();
        chk("acc spad4", spad[4], 24'd12);
        chk("acc idle busy", busy, 1'b0);
        chk("acc idle w_en", spad_w_en, 1'b0);

        push(5'd1, 16'd7, 1'b1);
        push(5'd2, 16'hFFFC, 1'b1);
        push(5'd1, 16'd3, 1'b0);
        push(5'd2, 16'hFFFC, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("ilv spad1", spad[1], 24'd10);
        chk("ilv spad2", spad[2], 24'hFFFFF8);

        push(5'd0, 16'd32767, 1'b1);
        for (int i = 0; i < 255; i++) push(5'd0, 16'd32767, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("sat+ 256", spad[0], 24'd8388352);
        push(5'd0, 16'd32767, 1'b0);
        chk("sat+ wdata", spad_wdata, 24'h7FFFFF);
        in_valid = 1'b0;
        tick();
        chk("sat+ 257", spad[0], 24'h7FFFFF);

        push(5'd0, 16'h8000, 1'b1);
        for (int i = 0; i < 255; i++) push(5'd0, 16'h8000, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("sat- 256", spad[0], 24'h800000);
        push(5'd0, 16'h8000, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("sat- 257", spad[0], 24'h800000);

        push(5'd0, 16'd11, 1'b1);
        push(5'd1, 16'd22, 1'b1);
        push(5'd2, 16'd33, 1'b1);
        in_valid = 1'b0;
        tick();
        flush     = 1'b1;
        flush_len = 6'd3;
        tick();
        flush = 1'b0;
        chk("drn wait in_ready", in_ready, 1'b0);
        chk("drn wait out_valid", out_valid, 1'b0);
        chk("drn wait busy", busy, 1'b1);
        tick();
        for (int k = 0; k < 6; k++) begin
            out_ready = rdy_pat[k];
            #1;
            chk("drn out_valid", out_valid, 1'b1);
            chk("drn out_data", out_data, dat_pat[k]);
            chk("drn out_last", out_last, last_pat[k]);
            chk("drn clear w_en", spad_w_en, rdy_pat[k]);
            tick();
        end
        out_ready = 1'b0;
        chk("drn done out_valid", out_valid, 1'b0);
        chk("drn done in_ready", in_ready, 1'b1);
        chk("drn clr0", spad[0], 24'd0);
        chk("drn clr1", spad[1], 24'd0);
        chk("drn clr2", spad[2], 24'd0);

        push(5'd0, 16'd5, 1'b1);
        in_prod   = 16'd1;
        in_first  = 1'b0;
        flush     = 1'b1;
        flush_len = 6'd1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("inf wait in_ready", in_ready, 1'b0);
        chk("inf wait out_valid", out_valid, 1'b0);
        chk("inf stage wdata", spad_wdata, 24'd6);
        tick();
        chk("inf drain valid", out_valid, 1'b1);
        chk("inf drain data", out_data, 24'd6);
        chk("inf drain last", out_last, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("inf idle out_valid", out_valid, 1'b0);
        chk("inf idle in_ready", in_ready, 1'b1);

        flush     = 1'b1;
        flush_len = 6'd0;
        tick();
        flush = 1'b0;
        chk("len0 in_ready", in_ready, 1'b1);
        chk("len0 busy", busy, 1'b0);

        flush     = 1'b1;
        flush_len = 6'd40;
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        cnt  = 0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (out_valid) begin
                cnt++;
                if (out_last) done = 1'b1;
            end
            tick();
        end
        out_ready = 1'b0;
        n_chk++;
        if (!done) begin
            n_fail++;
            $error("FAIL len40 drain wait expired after 100 cycles");
        end
        chk("len40 done", done, 1'b1);
        chk("len40 count", cnt, 32);
        chk("len40 in_ready", in_ready, 1'b1);

        flush     = 1'b1;
        flush_len = 6'd3;
        tick();
        flush = 1'b0;
        tick();
        chk("rst pre out_valid", out_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst in_ready", in_ready, 1'b1);
        #2;
        rst = 1'b1;
        tick();
        chk("rst after in_ready", in_ready, 1'b1);
        chk("rst after busy", busy, 1'b0);
        chk("rst after out_valid", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
